// File: rtl/riscv_pkg.sv
// Shared RV32IM encoding constants, the format-class enum and the field bundle
// carried through the encoder pipeline.
package riscv_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] SYSTEM = 7'b1110011;

  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD
  } fmt_e;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [31:0] imm;
  } fields_t;

  // True when v is representable as a signed value of the given width.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
    logic [31:0] s;
    s = $signed(v) >>> (bits - 1);
    return (s == 32'h0) || (s == 32'hFFFF_FFFF);
  endfunction

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational format classification, immediate scatter and legality check.
// Illegal bundles come out as the canonical NOP word.
module instr_encoder_pack
  import riscv_pkg::*;
(
  input  fields_t     f,
  output logic [31:0] word,
  output logic        bad,
  output fmt_e        fmt
);

  logic [31:0] raw;
  logic        ok;
  logic        shift;
  logic        fits12;

  assign shift  = (f.opcode == OP_IMM) && ((f.func3 == 3'b001) || (f.func3 == 3'b101));
  assign fits12 = fits_signed(f.imm, 12);

  always_comb begin
    fmt = FMT_BAD;
    raw = NOP;
    ok  = 1'b0;
    case (f.opcode)
      OP: begin
        fmt = FMT_R;
        raw = {f.func7, f.rs2, f.rs1, f.func3, f.rd, f.opcode};
        ok  = (f.func7 == 7'b0000000) || (f.func7 == 7'b0000001) ||
              ((f.func7 == 7'b0100000) && ((f.func3 == 3'b000) || (f.func3 == 3'b101)));
      end
      OP_IMM: begin
        fmt = FMT_I;
        if (shift) begin
          raw = {f.func7, f.imm[4:0], f.rs1, f.func3, f.rd, f.opcode};
          ok  = ((f.func7 == 7'b0000000) ||
                 ((f.func7 == 7'b0100000) && (f.func3 == 3'b101))) &&
                (f.imm[31:5] == 27'd0);
        end else begin
          raw = {f.imm[11:0], f.rs1, f.func3, f.rd, f.opcode};
          ok  = fits12;
        end
      end
      LOAD: begin
        fmt = FMT_I;
        raw = {f.imm[11:0], f.rs1, f.func3, f.rd, f.opcode};
        ok  = fits12 && (f.func3 != 3'b011) && (f.func3 != 3'b110) && (f.func3 != 3'b111);
      end
      JALR: begin
        fmt = FMT_I;
        raw = {f.imm[11:0], f.rs1, f.func3, f.rd, f.opcode};
        ok  = fits12 && (f.func3 == 3'b000);
      end
      SYSTEM: begin
        fmt = FMT_I;
        raw = {f.imm[11:0], f.rs1, f.func3, f.rd, f.opcode};
        ok  = (f.rd == 5'd0) && (f.rs1 == 5'd0) && (f.func3 == 3'b000) &&
              ((f.imm == 32'd0) || (f.imm == 32'd1));
      end
      STORE: begin
        fmt = FMT_S;
        raw = {f.imm[11:5], f.rs2, f.rs1, f.func3, f.imm[4:0], f.opcode};
        ok  = fits12 && (f.func3 <= 3'b010);
      end
      BRANCH: begin
        fmt = FMT_B;
        raw = {f.imm[12], f.imm[10:5], f.rs2, f.rs1, f.func3, f.imm[4:1], f.imm[11], f.opcode};
        ok  = fits_signed(f.imm, 13) && !f.imm[0] &&
              (f.func3 != 3'b010) && (f.func3 != 3'b011);
      end
      LUI, AUIPC: begin
        fmt = FMT_U;
        raw = {f.imm[31:12], f.rd, f.opcode};
        ok  = (f.imm[11:0] == 12'd0);
      end
      JAL: begin
        fmt = FMT_J;
        raw = {f.imm[20], f.imm[10:1], f.imm[11], f.imm[19:12], f.rd, f.opcode};
        ok  = fits_signed(f.imm, 21) && !f.imm[0];
      end
      default: begin
        fmt = FMT_BAD;
        raw = NOP;
        ok  = 1'b0;
      end
    endcase
  end

  assign bad  = !ok;
  assign word = ok ? raw : NOP;

endmodule

// File: rtl/instr_encoder.sv
// Two-stage RV32IM instruction encoder: S1 holds the raw bundle, S2 the packed
// word. Owns the valid/ready handshake and the saturating reject counter.
module instr_encoder
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  func3,
  input  logic [6:0]  func7,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr,
  output logic        illegal,
  output logic [15:0] illegal_count
);

  // Handshake: a transfer happens on an edge where valid && ready; valid never
  // depends on ready, and in_ready depends only on state and out_ready.
  fields_t     s1_q;
  logic        s1_valid;
  logic        s1_ready;
  logic        s2_advance;
  logic [15:0] cnt_q;
  logic [31:0] pack_word;
  logic        pack_bad;
  fmt_e        pack_fmt;
  fields_t     in_fields;

  assign in_fields     = '{opcode: opcode, rd: rd, rs1: rs1, rs2: rs2,
                           func3: func3, func7: func7, imm: imm};
  assign s2_advance    = !out_valid || out_ready;
  assign s1_ready      = !s1_valid || s2_advance;
  assign in_ready      = rst || s1_ready;
  assign illegal_count = cnt_q;

  instr_encoder_pack u_pack (
    .f    (s1_q),
    .word (pack_word),
    .bad  (pack_bad),
    .fmt  (pack_fmt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      instr     <= NOP;
      illegal   <= 1'b0;
      cnt_q     <= 16'd0;
    end else begin
      if (s2_advance) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          instr   <= pack_word;
          illegal <= pack_bad;
          if (pack_bad && (cnt_q != 16'hFFFF)) cnt_q <= cnt_q + 16'd1;
        end
      end
      if (s1_ready) begin
        s1_valid <= in_valid;
        if (in_valid) s1_q <= in_fields;
      end
    end
  end

endmodule
